// File: rtl/trace_capture_writer.sv
// Passive Avalon-ST tap that stores accepted beats into a circular trace buffer
// over Avalon-MM, with pre-trigger history and a programmable post-trigger depth.
module trace_capture_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_in,
    input  logic              trig_sop_en,
    input  logic [ADDR_W:0]   post_count,
    input  logic              asi_valid,
    input  logic [DATA_W-1:0] asi_data,
    input  logic              asi_startofpacket,
    output logic              asi_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [1:0]        state,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] wr_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRETRIG  = 2'd1,
        ST_POSTTRIG = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_t              state_r;
    state_t              next_state_s;
    logic                accept_s;
    logic                trig_event_s;
    logic                do_write_s;
    logic                do_arm_s;
    logic                trig_hit_s;
    logic                dec_s;
    logic [ADDR_W:0]     post_latch_s;
    logic [ADDR_W:0]     remaining_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_address_r;
    logic [DATA_W-1:0]   mem_writedata_r;
    logic                done_r;
    logic                wrapped_r;
    logic [ADDR_W-1:0]   trig_addr_r;
    logic [ADDR_W-1:0]   wr_ptr_r;

    assign asi_ready      = 1'b1;
    assign mem_byteenable = 4'hF;
    assign accept_s       = asi_valid;
    assign trig_event_s   = accept_s & (trig_in | (trig_sop_en & asi_startofpacket));

    assign mem_write      = mem_write_r;
    assign mem_chipselect = mem_write_r;
    assign mem_address    = mem_address_r;
    assign mem_writedata  = mem_writedata_r;
    assign state          = state_r;
    assign done           = done_r;
    assign wrapped        = wrapped_r;
    assign trig_addr      = trig_addr_r;
    assign wr_ptr         = wr_ptr_r;

    // Normalise the requested post-trigger depth into the range 1..DEPTH
    always_comb begin
        post_latch_s = post_count;
        if (post_count == CNT_ZERO) begin
            post_latch_s = CNT_ONE;
        end else if (post_count > DEPTH_C) begin
            post_latch_s = DEPTH_C;
        end else begin
            post_latch_s = post_count;
        end
    end

    // Capture state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-cycle datapath controls; abort overrides everything
    always_comb begin
        next_state_s = state_r;
        do_write_s   = 1'b0;
        do_arm_s     = 1'b0;
        trig_hit_s   = 1'b0;
        dec_s        = 1'b0;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        next_state_s = ST_PRETRIG;
                        do_arm_s     = 1'b1;
                    end else begin
                        next_state_s = state_r;
                    end
                end
                ST_PRETRIG: begin
                    if (accept_s) begin
                        do_write_s = 1'b1;
                        if (trig_event_s) begin
                            trig_hit_s = 1'b1;
                            dec_s      = 1'b1;
                            if (remaining_r == CNT_ONE) begin
                                next_state_s = ST_DONE;
                            end else begin
                                next_state_s = ST_POSTTRIG;
                            end
                        end else begin
                            next_state_s = ST_PRETRIG;
                        end
                    end else begin
                        next_state_s = ST_PRETRIG;
                    end
                end
                ST_POSTTRIG: begin
                    if (accept_s) begin
                        do_write_s = 1'b1;
                        dec_s      = 1'b1;
                        if (remaining_r == CNT_ONE) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_state_s = ST_POSTTRIG;
                        end
                    end else begin
                        next_state_s = ST_POSTTRIG;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Registered memory write port: one strobe per stored beat, one cycle after acceptance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_write_r     <= 1'b0;
            mem_address_r   <= PTR_ZERO;
            mem_writedata_r <= {DATA_W{1'b0}};
        end else begin
            mem_write_r <= do_write_s;
            if (do_write_s) begin
                mem_address_r   <= wr_ptr_r;
                mem_writedata_r <= asi_data;
            end else begin
                mem_address_r   <= mem_address_r;
                mem_writedata_r <= mem_writedata_r;
            end
        end
    end

    // Buffer bookkeeping: write pointer, wrap flag, trigger address and remaining depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= PTR_ZERO;
            wrapped_r   <= 1'b0;
            trig_addr_r <= PTR_ZERO;
            remaining_r <= CNT_ZERO;
        end else if (do_arm_s) begin
            wr_ptr_r    <= PTR_ZERO;
            wrapped_r   <= 1'b0;
            trig_addr_r <= PTR_ZERO;
            remaining_r <= post_latch_s;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (wr_ptr_r == PTR_LAST) begin
                    wrapped_r <= 1'b1;
                end
            end
            if (trig_hit_s) begin
                trig_addr_r <= wr_ptr_r;
            end
            if (dec_s) begin
                remaining_r <= remaining_r - CNT_ONE;
            end
        end
    end

    // Completion flag registered alongside the state it mirrors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (next_state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_trace_capture_writer.sv
// Directed bench for trace_capture_writer: idle drop, trigger capture, wrap,
// SOP trigger, gapped stream, depth clamp, abort and mid-capture reset.
module tb_trace_capture_writer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic              abort;
    logic              trig_in;
    logic              trig_sop_en;
    logic [ADDR_W:0]   post_count;
    logic              asi_valid;
    logic [DATA_W-1:0] asi_data;
    logic              asi_startofpacket;
    logic              asi_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [1:0]        state;
    logic              done;
    logic              wrapped;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] wr_ptr;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int base = 0;

    trace_capture_writer dut (
        .clk               (clk),
        .reset             (reset),
        .arm               (arm),
        .abort             (abort),
        .trig_in           (trig_in),
        .trig_sop_en       (trig_sop_en),
        .post_count        (post_count),
        .asi_valid         (asi_valid),
        .asi_data          (asi_data),
        .asi_startofpacket (asi_startofpacket),
        .asi_ready         (asi_ready),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .state             (state),
        .done              (done),
        .wrapped           (wrapped),
        .trig_addr         (trig_addr),
        .wr_ptr            (wr_ptr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic t, input logic s);
        asi_valid = v;
        asi_data = d;
        trig_in = t;
        asi_startofpacket = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [ADDR_W:0] pc);
        arm = 1'b1;
        post_count = pc;
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0; trig_sop_en = 1'b0;
        post_count = '0; asi_valid = 1'b0; asi_data = '0; asi_startofpacket = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_writedata", mem_writedata, 32'd0);
        check("byteenable", 32'(mem_byteenable), 32'hF);
        reset = 1'b0;

        // Beats with no arm are dropped
        base = wr_count;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
            check("idle_no_write", 32'(mem_write), 32'd0);
            check("idle_ready", 32'(asi_ready), 32'd1);
        end
        check("idle_state", 32'(state), 32'd0);
        check("idle_write_count", 32'(wr_count - base), 32'd0);

        // post_count=4, trigger on beat 0xA5
        do_arm(14'd4);
        check("arm_state", 32'(state), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'hA0 + 32'(i), (i == 5), 1'b0);
            if (i <= 8) begin
                check("t1_write", 32'(mem_write), 32'd1);
                check("t1_addr", 32'(mem_address), 32'(i));
                check("t1_data", mem_writedata, 32'hA0 + 32'(i));
            end else begin
                check("t1_drop_after_done", 32'(mem_write), 32'd0);
            end
        end
        check("t1_trig_addr", 32'(trig_addr), 32'd5);
        check("t1_wr_ptr", 32'(wr_ptr), 32'd9);
        check("t1_done", 32'(done), 32'd1);
        check("t1_wrapped", 32'(wrapped), 32'd0);
        check("t1_state", 32'(state), 32'd3);

        // Re-arm from DONE; 8200 pre-trigger beats wrap the buffer
        do_arm(14'd2);
        check("t2_rearm_state", 32'(state), 32'd1);
        check("t2_rearm_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t2_rearm_wrapped", 32'(wrapped), 32'd0);
        for (int i = 0; i < 8200; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 8190) check("t2_not_wrapped_yet", 32'(wrapped), 32'd0);
            if (i == 8191) begin
                check("t2_wrapped", 32'(wrapped), 32'd1);
                check("t2_ptr_wrap", 32'(wr_ptr), 32'd0);
            end
        end
        cyc(1'b1, 32'hBEEF, 1'b1, 1'b0);
        check("t2_trig_state", 32'(state), 32'd2);
        check("t2_trig_addr", 32'(trig_addr), 32'd8);
        check("t2_trig_mem_addr", 32'(mem_address), 32'd8);
        cyc(1'b1, 32'hCAFE, 1'b0, 1'b0);
        check("t2_state", 32'(state), 32'd3);
        check("t2_wr_ptr", 32'(wr_ptr), 32'd10);
        check("t2_last_addr", 32'(mem_address), 32'd9);
        check("t2_last_data", mem_writedata, 32'hCAFE);
        check("t2_wrapped_held", 32'(wrapped), 32'd1);

        // SOP trigger with post_count=0 (treated as 1)
        trig_sop_en = 1'b1;
        do_arm(14'd0);
        base = wr_count;
        cyc(1'b1, 32'hB0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b0, 1'b0);
        check("t3_pretrig", 32'(state), 32'd1);
        check("t3_done_low", 32'(done), 32'd0);
        cyc(1'b1, 32'hB2, 1'b0, 1'b1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_trig_addr", 32'(trig_addr), 32'd2);
        check("t3_addr", 32'(mem_address), 32'd2);
        check("t3_data", mem_writedata, 32'hB2);
        cyc(1'b1, 32'hB3, 1'b0, 1'b1);
        check("t3_no_extra", 32'(mem_write), 32'd0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        check("t3_count", 32'(wr_count - base), 32'd3);
        check("t3_wr_ptr", 32'(wr_ptr), 32'd3);
        trig_sop_en = 1'b0;

        // Gapped stream (1 valid in 3), post_count=3
        do_arm(14'd3);
        base = wr_count;
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        check("t4_trig_needs_valid", 32'(state), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 32'hC0 + 32'(k), (k == 1), 1'b0);
            check("t4_write", 32'(mem_write), 32'(k < 4));
            if (k < 4) check("t4_addr", 32'(mem_address), 32'(k));
            cyc(1'b0, 32'd0, 1'b0, 1'b0);
            check("t4_gap1", 32'(mem_write), 32'd0);
            cyc(1'b0, 32'd0, 1'b0, 1'b0);
            check("t4_gap2", 32'(mem_write), 32'd0);
        end
        check("t4_state", 32'(state), 32'd3);
        check("t4_wr_ptr", 32'(wr_ptr), 32'd4);
        check("t4_trig_addr", 32'(trig_addr), 32'd1);
        check("t4_count", 32'(wr_count - base), 32'd4);

        // post_count above DEPTH clamps to DEPTH
        do_arm(14'd9000);
        cyc(1'b1, 32'h5000, 1'b1, 1'b0);
        for (int i = 1; i < 8192; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 8190) check("t5_still_post", 32'(state), 32'd2);
        end
        check("t5_state", 32'(state), 32'd3);
        check("t5_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t5_wrapped", 32'(wrapped), 32'd1);
        check("t5_trig_addr", 32'(trig_addr), 32'd0);
        check("t5_last_addr", 32'(mem_address), 32'd8191);

        // Abort mid-POSTTRIG
        do_arm(14'd5);
        cyc(1'b1, 32'hD0, 1'b1, 1'b0);
        cyc(1'b1, 32'hD1, 1'b0, 1'b0);
        check("t6_post", 32'(state), 32'd2);
        abort = 1'b1;
        cyc(1'b1, 32'hD2, 1'b0, 1'b0);
        abort = 1'b0;
        check("t6_abort_state", 32'(state), 32'd0);
        check("t6_abort_no_write", 32'(mem_write), 32'd0);
        check("t6_wr_ptr_kept", 32'(wr_ptr), 32'd2);
        cyc(1'b1, 32'hD3, 1'b0, 1'b0);
        check("t6_idle_drop", 32'(mem_write), 32'd0);
        arm = 1'b1;
        abort = 1'b1;
        post_count = 14'd2;
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        arm = 1'b0;
        abort = 1'b0;
        check("t6_abort_wins", 32'(state), 32'd0);
        check("t6_abort_wins_ptr", 32'(wr_ptr), 32'd2);

        // Reset with a write pending in POSTTRIG
        do_arm(14'd4);
        cyc(1'b1, 32'hE0, 1'b1, 1'b0);
        cyc(1'b1, 32'hE1, 1'b0, 1'b0);
        check("t7_pending", 32'(mem_write), 32'd1);
        asi_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t7_rst_write", 32'(mem_write), 32'd0);
        check("t7_rst_state", 32'(state), 32'd0);
        check("t7_rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("t7_rst_addr", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_arm(14'd2);
        cyc(1'b1, 32'hF0, 1'b1, 1'b0);
        check("t7_addr0", 32'(mem_address), 32'd0);
        check("t7_data0", mem_writedata, 32'hF0);
        cyc(1'b1, 32'hF1, 1'b0, 1'b0);
        check("t7_addr1", 32'(mem_address), 32'd1);
        check("t7_state", 32'(state), 32'd3);
        check("t7_wr_ptr", 32'(wr_ptr), 32'd2);
        check("t7_trig_addr", 32'(trig_addr), 32'd0);
        check("t7_wrapped", 32'(wrapped), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trace_capture_writer.md
Name: trace_capture_writer

Overview:
- Upstream feeder for the 8192x32 trace-system on-chip memory.
- Taps an Avalon-ST stream and writes each accepted beat into the memory's Avalon-MM slave port as a circular buffer.
- Supports a pre-trigger history window, a trigger event, and a programmable post-trigger depth.
- Exposes status (state, trigger address, final write pointer, wrap flag) so software can unroll the buffer after capture.

Parameters:
- DATA_W, 32, stream and memory word width.
- ADDR_W, 13, memory word-address width.
- DEPTH, 8192, buffer words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- arm  in  1  single-cycle pulse; starts a capture
- abort  in  1  single-cycle pulse; returns to IDLE
- trig_in  in  1  external trigger, sampled only while a beat is accepted
- trig_sop_en  in  1  when 1, asi_startofpacket on an accepted beat also triggers
- post_count  in  ADDR_W+1  beats to store from the trigger beat inclusive; sampled on arm
- asi_valid  in  1  stream beat valid
- asi_data  in  DATA_W  stream data
- asi_startofpacket  in  1  stream SOP
- asi_ready  out  1  always 1; passive tap, never backpressures
- mem_address  out  ADDR_W  memory word address
- mem_byteenable  out  4  constant 4'hF
- mem_chipselect  out  1  equals mem_write
- mem_write  out  1  write strobe
- mem_writedata  out  DATA_W  word to store
- state  out  2  0=IDLE, 1=PRETRIG, 2=POSTTRIG, 3=DONE
- done  out  1  state==DONE
- wrapped  out  1  write pointer has wrapped since arm
- trig_addr  out  ADDR_W  address holding the trigger beat
- wr_ptr  out  ADDR_W  next address to be written

Behaviour:
- Reset values: state=IDLE. mem_write, mem_chipselect, wrapped, done = 0. mem_address, mem_writedata, trig_addr, wr_ptr = 0. asi_ready=1 and mem_byteenable=4'hF at all times.
- Accepted beat: asi_valid & asi_ready, so effectively asi_valid.
- Trigger event: accepted beat & (trig_in | (trig_sop_en & asi_startofpacket)).
- Latency: every beat stored is presented on the memory port exactly 1 cycle after acceptance. mem_write is registered and high for one cycle per beat; mem_address is the wr_ptr value at acceptance. The memory has no waitrequest, so a write is always accepted.
- Beats accepted in IDLE or DONE are dropped; no write is issued.

Post-count latch, on arm:
- post_count==0 is treated as 1.
- Values greater than DEPTH are clamped to DEPTH.

State machine:
- IDLE -> PRETRIG on arm. Same cycle: wr_ptr<=0, wrapped<=0, trig_addr<=0, remaining<=latched post_count.
- PRETRIG:
  - Every accepted beat is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - On the increment from DEPTH-1 to 0, wrapped<=1 (sticky until next arm).
  - On a trigger event: the beat is written, trig_addr<=wr_ptr, remaining decrements.
  - Trigger with latched count 1 -> DONE. Otherwise -> POSTTRIG.
- POSTTRIG:
  - Accepted beats are written; triggers are ignored; remaining decrements per beat.
  - When remaining reaches 0 after a write -> DONE.
- DONE:
  - Holds wr_ptr, trig_addr and wrapped stable for software readout.
  - The final pending write from the last beat still completes on the next cycle.
- arm is honoured only in IDLE or DONE (DONE -> PRETRIG re-arms). arm is ignored in PRETRIG/POSTTRIG.
- abort from any state -> IDLE next cycle. A write already registered still completes. wr_ptr, trig_addr and wrapped are retained.
- arm and abort in the same cycle: abort wins.

Readout rule for software:
- wrapped=1: the oldest word is at wr_ptr.
- wrapped=0: the oldest word is at 0.
- Post-trigger depth equal to DEPTH overwrites all pre-trigger history. This is legal.

Reset asserted mid-capture: all outputs return to reset values asynchronously. Any in-flight write is lost.

Test Plan:
- Reset, then 10 valid beats with no arm -> mem_write never asserts; state=0; asi_ready=1 throughout.
- arm with post_count=4; beats 0xA0..0xA9 with trig_in on beat 0xA5 -> writes to addresses 0..8 carrying 0xA0..0xA8. trig_addr=5, wr_ptr=9, done=1, wrapped=0. Each write lags its beat by 1 cycle.
- arm with post_count=2; 8200 beats before the trigger beat -> wrapped=1. trig_addr=(8200 mod 8192)=8, wr_ptr=10, state=3.
- trig_sop_en=1, post_count=0; SOP on 3rd beat -> exactly one post-trigger write. trig_addr=2, done asserts the cycle after the trigger beat.
- Gapped valid (1 of every 3 cycles) with post_count=3 after the trigger -> exactly 3 writes on consecutive addresses, no write in gap cycles. abort mid-POSTTRIG on a repeat run -> state=0 next cycle, no further writes.
- Assert reset while in POSTTRIG with a write pending -> mem_write=0 immediately; state=0, wr_ptr=0. A subsequent arm captures correctly from address 0.
